// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one memory port between instruction fetch (I) and the memory stage
//   (D). One transaction is in flight at a time. When both ask together, the
//   requester that did not own the previous transaction wins. The request
//   toward memory is registered and held stable until memory acks or the
//   watchdog expires. The ack, error and read data go back to the owner only.
//
// Parameters
//   XLEN    : data/address width
//   TIMEOUT : BUSY cycles without i_mem_ack before an error (0 = no watchdog)
//   TO_W    : watchdog counter width (TIMEOUT < 2**TO_W)
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_flush                    drops the I response of an in-flight fetch
//   i_i_req/i_i_addr           fetch request (word read)
//   o_i_ack/o_i_rdata/o_i_err  fetch response pulses and data
//   i_d_req/addr/wdata/we/funct3  data request
//   o_d_ack/o_d_rdata/o_d_err  data response pulses and data
//   o_mem_req/addr/wdata/we/funct3  registered request toward memory
//   i_mem_ack/i_mem_rdata      memory completion and read data
//   o_busy                     arbiter not idle
//   o_grant                    current or last owner (0 = I, 1 = D)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_i_req,
  input  logic [XLEN-1:0] i_i_addr,
  output logic            o_i_ack,
  output logic [XLEN-1:0] o_i_rdata,
  output logic            o_i_err,
  input  logic            i_d_req,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wdata,
  input  logic            i_d_we,
  input  logic [2:0]      i_d_funct3,
  output logic            o_d_ack,
  output logic [XLEN-1:0] o_d_rdata,
  output logic            o_d_err,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic            o_mem_we,
  output logic [2:0]      o_mem_funct3,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_busy,
  output logic            o_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic            OWN_I    = 1'b0;
  localparam logic            OWN_D    = 1'b1;
  localparam logic [2:0]      F3_WORD  = 3'b010;
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic            WD_EN    = (TIMEOUT != 32'sd0);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              flush_q, flush_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic              i_ack_q, i_ack_d;
  logic              i_err_q, i_err_d;
  logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              grant_q, grant_d;

  logic              sel_owner_s;
  logic              suppress_i_s;
  logic              timeout_s;
  logic [TO_W-1:0]   wd_inc_s;

  // Round-robin pick: on a tie the requester that was not last served wins.
  always_comb begin
    sel_owner_s = OWN_I;
    if (i_d_req && i_i_req) begin
      sel_owner_s = ~last_owner_q;
    end else if (i_d_req) begin
      sel_owner_s = OWN_D;
    end else begin
      sel_owner_s = OWN_I;
    end
  end

  // Watchdog increment (saturating so a disabled watchdog never wraps) and
  // the I-response suppression, which also honours a flush at the final edge.
  always_comb begin
    wd_inc_s     = (wd_q == {TO_W{1'b1}}) ? wd_q : (wd_q + TO_ONE);
    timeout_s    = WD_EN && (wd_inc_s == TO_LIMIT);
    suppress_i_s = (owner_q == OWN_I) && (flush_q || i_flush);
  end

  // Next-state and next-output logic for the IDLE/BUSY/RESP controller.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    flush_d      = flush_q;
    wd_d         = wd_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    mem_funct3_d = mem_funct3_q;
    i_ack_d      = 1'b0;
    i_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    grant_d      = grant_q;

    case (state_q)
      ST_IDLE: begin
        if (i_d_req || i_i_req) begin
          owner_d   = sel_owner_s;
          grant_d   = sel_owner_s;
          flush_d   = 1'b0;
          wd_d      = {TO_W{1'b0}};
          mem_req_d = 1'b1;
          state_d   = ST_BUSY;
          if (sel_owner_s == OWN_D) begin
            mem_addr_d   = i_d_addr;
            mem_wdata_d  = i_d_wdata;
            mem_we_d     = i_d_we;
            mem_funct3_d = i_d_funct3;
          end else begin
            mem_addr_d   = i_i_addr;
            mem_wdata_d  = ZERO_X;
            mem_we_d     = 1'b0;
            mem_funct3_d = F3_WORD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        // A flush only ever matters for a fetch; sticky until the next grant.
        flush_d = flush_q | ((owner_q == OWN_I) & i_flush);
        // Ack is checked first so that it beats a coincident timeout.
        if (i_mem_ack || timeout_s) begin
          mem_req_d    = 1'b0;
          mem_addr_d   = ZERO_X;
          mem_wdata_d  = ZERO_X;
          mem_we_d     = 1'b0;
          mem_funct3_d = 3'b000;
          state_d      = ST_RESP;
          if (owner_q == OWN_D) begin
            if (i_mem_ack) begin
              d_ack_d   = 1'b1;
              d_rdata_d = i_mem_rdata;
            end else begin
              d_err_d   = 1'b1;
              d_rdata_d = ZERO_X;
            end
          end else if (!suppress_i_s) begin
            if (i_mem_ack) begin
              i_ack_d   = 1'b1;
              i_rdata_d = i_mem_rdata;
            end else begin
              i_err_d   = 1'b1;
              i_rdata_d = ZERO_X;
            end
          end else begin
            i_ack_d = 1'b0;
          end
        end else begin
          wd_d = wd_inc_s;
        end
      end

      ST_RESP: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      flush_q      <= 1'b0;
      wd_q         <= {TO_W{1'b0}};
      mem_req_q    <= 1'b0;
      mem_addr_q   <= ZERO_X;
      mem_wdata_q  <= ZERO_X;
      mem_we_q     <= 1'b0;
      mem_funct3_q <= 3'b000;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= ZERO_X;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= ZERO_X;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      flush_q      <= flush_d;
      wd_q         <= wd_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_funct3_q <= mem_funct3_d;
      i_ack_q      <= i_ack_d;
      i_err_q      <= i_err_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
    end
  end

  assign o_i_ack      = i_ack_q;
  assign o_i_err      = i_err_q;
  assign o_i_rdata    = i_rdata_q;
  assign o_d_ack      = d_ack_q;
  assign o_d_err      = d_err_q;
  assign o_d_rdata    = d_rdata_q;
  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_funct3 = mem_funct3_q;
  assign o_busy       = busy_q;
  assign o_grant      = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (TIMEOUT = 4). Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_rdata;
  logic            i_err;
  logic            d_req;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_we;
  logic [2:0]      d_funct3;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_we;
  logic [2:0]      mem_funct3;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            busy;
  logic            grant;

  int tests_run;
  int tests_failed;

  mem_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(4), .TO_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_ack(i_ack), .o_i_rdata(i_rdata), .o_i_err(i_err),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_we(d_we), .i_d_funct3(d_funct3),
    .o_d_ack(d_ack), .o_d_rdata(d_rdata), .o_d_err(d_err),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .o_mem_funct3(mem_funct3), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_we = 1'b0; d_funct3 = 3'b000;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({mem_req, busy, grant, i_ack, i_err, d_ack, d_err, mem_we} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {mem_req, busy, grant, i_ack, i_err, d_ack, d_err, mem_we});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata, mem_funct3} !== {128'h0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_data: addr %h wdata %h irdata %h drdata %h f3 %b expected all 0",
               mem_addr, mem_wdata, i_rdata, d_rdata, mem_funct3);
    end
  endtask

  task automatic test_d_only();
    int req_cnt;
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_funct3 = 3'b010; d_wdata = 32'h0;
    tick();  // grant edge
    tests_run++;
    if ({mem_req, busy, grant, mem_we, mem_funct3} !== {3'b111, 1'b0, 3'b010}) begin
      tests_failed++;
      $display("FAIL d_only_grant: req/busy/grant/we/f3 got %b expected 1110010",
               {mem_req, busy, grant, mem_we, mem_funct3});
    end
    tests_run++;
    if (mem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL d_only_addr: got %h expected 00000100", mem_addr);
    end
    req_cnt = mem_req ? 1 : 0;
    tick(); if (mem_req) req_cnt++;
    tick(); if (mem_req) req_cnt++;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();  // ack sampled
    mem_ack = 1'b0; mem_rdata = 32'h0; d_req = 1'b0;
    if (mem_req) req_cnt++;
    tests_run++;
    if (req_cnt !== 3) begin
      tests_failed++;
      $display("FAIL d_only_req_cycles: got %0d expected 3", req_cnt);
    end
    tests_run++;
    if ({d_ack, d_err, i_ack} !== 3'b100 || d_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL d_only_ack: ack/err/iack %b rdata %h expected 100 deadbeef",
               {d_ack, d_err, i_ack}, d_rdata);
    end
    tests_run++;
    if ({mem_addr, mem_funct3} !== {32'h0, 3'b000}) begin
      tests_failed++;
      $display("FAIL d_only_fields_zeroed: addr %h f3 %b expected 0 000", mem_addr, mem_funct3);
    end
    tick();  // RESP -> IDLE
    tests_run++;
    if ({d_ack, busy} !== 2'b00 || d_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL d_only_after_resp: ack/busy %b rdata %h expected 00 deadbeef",
               {d_ack, busy}, d_rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_funct3 = 3'b010; d_wdata = 32'hCAFE0000;
    tick();
    tests_run++;
    if (grant !== 1'b1 || mem_addr !== 32'h300) begin
      tests_failed++;
      $display("FAIL simul_first_d: grant %b addr %h expected 1 00000300", grant, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h11;
    tick();
    mem_ack = 1'b0;
    tests_run++;
    if ({d_ack, i_ack} !== 2'b10) begin
      tests_failed++;
      $display("FAIL simul_d_ack: d/i ack %b expected 10", {d_ack, i_ack});
    end
    d_req = 1'b0;
    tick();  // RESP -> IDLE
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_gap: mem_req %b expected 0", mem_req);
    end
    tick();
    tests_run++;
    if ({mem_req, grant, mem_we, mem_funct3} !== {1'b1, 1'b0, 1'b0, 3'b010} ||
        mem_addr !== 32'h200 || mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL simul_then_i: req/grant/we/f3 %b addr %h wdata %h expected 100010 00000200 0",
               {mem_req, grant, mem_we, mem_funct3}, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h22;
    tick();
    mem_ack = 1'b0;
    tests_run++;
    if ({i_ack, d_ack} !== 2'b10 || i_rdata !== 32'h22) begin
      tests_failed++;
      $display("FAIL simul_i_ack: i/d ack %b rdata %h expected 10 00000022", {i_ack, d_ack}, i_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_g;
    i_req = 1'b1; i_addr = 32'h240;
    d_req = 1'b1; d_addr = 32'h340; d_we = 1'b0; d_funct3 = 3'b010;
    for (int t = 0; t < 4; t++) begin
      exp_g = ((t % 2) == 0) ? 1'b1 : 1'b0;
      tick();  // grant edge
      tests_run++;
      if (grant !== exp_g || mem_req !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: grant %b req %b expected %b 1", t, grant, mem_req, exp_g);
      end
      mem_ack = 1'b1; mem_rdata = 32'h1000 + t;
      tick();
      mem_ack = 1'b0;
      tests_run++;
      if ({d_ack, i_ack} !== {exp_g, ~exp_g}) begin
        tests_failed++;
        $display("FAIL rr_ack_%0d: d/i ack %b expected %b", t, {d_ack, i_ack}, {exp_g, ~exp_g});
      end
      tick();  // RESP -> IDLE
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int req_cnt;
    int err_cnt;
    int ack_cnt;
    d_req = 1'b1; d_addr = 32'h3; d_wdata = 32'hAB; d_we = 1'b1; d_funct3 = 3'b000;
    tick();
    tests_run++;
    if ({mem_we, mem_funct3} !== 4'b1000 || mem_addr !== 32'h3 || mem_wdata !== 32'hAB) begin
      tests_failed++;
      $display("FAIL to_fields: we/f3 %b addr %h wdata %h expected 1000 3 ab",
               {mem_we, mem_funct3}, mem_addr, mem_wdata);
    end
    req_cnt = mem_req ? 1 : 0;
    err_cnt = 0;
    ack_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_req) req_cnt++;
      if (d_ack) ack_cnt++;
      if (d_err) begin
        err_cnt++;
        d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    tests_run++;
    if (req_cnt !== 4) begin
      tests_failed++;
      $display("FAIL to_req_cycles: got %0d expected 4", req_cnt);
    end
    tests_run++;
    if (err_cnt !== 1 || ack_cnt !== 0) begin
      tests_failed++;
      $display("FAIL to_err_pulse: err %0d ack %0d expected 1 0", err_cnt, ack_cnt);
    end
    tests_run++;
    if (d_rdata !== 32'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_rdata_idle: rdata %h busy %b expected 0 0", d_rdata, busy);
    end
  endtask

  task automatic test_flush();
    i_req = 1'b1; i_addr = 32'h400;
    tick();
    tests_run++;
    if (grant !== 1'b0 || mem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_grant_i: grant %b req %b expected 0 1", grant, mem_req);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h13;
    tick();
    mem_ack = 1'b0;
    tests_run++;
    if ({mem_req, i_ack, i_err, busy} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL flush_suppress: req/iack/ierr/busy %b expected 0001", {mem_req, i_ack, i_err, busy});
    end
    // Both ask now; the flushed fetch still counts as I's turn, so D wins.
    d_req = 1'b1; d_addr = 32'h500; d_we = 1'b0; d_funct3 = 3'b010;
    tick();  // RESP -> IDLE
    tests_run++;
    if (i_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_late_ack: got %b expected 0", i_ack);
    end
    tick();
    tests_run++;
    if ({mem_req, grant} !== 2'b11 || mem_addr !== 32'h500) begin
      tests_failed++;
      $display("FAIL flush_next_grant: req/grant %b addr %h expected 11 00000500", {mem_req, grant}, mem_addr);
    end
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    flush = 1'b0; mem_ack = 1'b0; d_req = 1'b0; i_req = 1'b0;
    tests_run++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h55) begin
      tests_failed++;
      $display("FAIL flush_d_unaffected: ack %b rdata %h expected 1 00000055", d_ack, d_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0; d_funct3 = 3'b010;
    tick();
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({mem_req, busy, grant, d_ack, d_err} !== 5'b00000 || d_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_busy: req/busy/grant/ack/err %b rdata %h addr %h expected 00000 0 0",
               {mem_req, busy, grant, d_ack, d_err}, d_rdata, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    tick();
    tests_run++;
    if ({mem_req, busy, d_ack, i_ack} !== 4'b0000 || d_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_stray_ack: req/busy/dack/iack %b rdata %h expected 0000 0",
               {mem_req, busy, d_ack, i_ack}, d_rdata);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_d_only();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
